floating_point_stim_gen: RTL and testbench

//  Onboard stimulus sequencer for the flt_pds2 floating-point core test. Reads operand pairs from the

---
 rtl/floating_point_pkg.sv | 17 +
 rtl/floating_point_stim_skid.sv | 59 +++++
 rtl/floating_point_stim_gen.sv | 132 +++++++++++++
 tb/tb_floating_point_stim_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floating_point_pkg.sv
// Shared constants, state encoding and operand-width helper for the FP core stimulus sequencer.
package floating_point_pkg;

    localparam int ROM_AW          = 4;
    localparam int STIM_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stim_state_e;

    function automatic int fp_width(input int exp_width, input int man_width);
        return 1 + exp_width + man_width;
    endfunction

endpackage

// File: rtl/floating_point_stim_skid.sv
// Two-entry register FIFO; slot 0 is always the head so the stream outputs come straight from a flop.
module floating_point_stim_skid
    import floating_point_pkg::*;
#(
    parameter int DW = 69,
    localparam int CW = $clog2(STIM_FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [STIM_FIFO_DEPTH];
    logic [DW-1:0] mem_d [STIM_FIFO_DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                mem_d[cnt_q[0]] = push_data;
                cnt_d           = cnt_q + 1'b1;
            end
            2'b01: begin
                mem_d[0] = mem_q[1];
                cnt_d    = cnt_q - 1'b1;
            end
            2'b11: begin
                if (cnt_q == CW'(2)) begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = push_data;
                end else begin
                    mem_d[0] = push_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: storage is reset too, because the head slot drives tdata/tuser/tlast, which must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STIM_FIFO_DEPTH; i++) mem_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_data = mem_q[0];
    assign count     = cnt_q;

endmodule

// File: rtl/floating_point_stim_gen.sv
// Stimulus sequencer: walks the operand ROMs and streams {B, A} pairs to the FP core over AXI4-Stream.
module floating_point_stim_gen
    import floating_point_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int NUM_VEC   = 10,
    localparam int W        = fp_width(EXP_WIDTH, MAN_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_rd_addr,
    input  logic [W-1:0]      rom_a_dout,
    input  logic [W-1:0]      rom_b_dout,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [2*W-1:0]    m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [ROM_AW-1:0] m_axis_tuser
);

    localparam int DW  = 2*W + ROM_AW + 1;
    localparam int CW  = ROM_AW + 1;
    localparam int FCW = $clog2(STIM_FIFO_DEPTH + 1);
    localparam int OW  = FCW + 1;
    localparam logic [CW-1:0]     NUM_VEC_C = CW'(NUM_VEC);
    localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(NUM_VEC - 1);

    stim_state_e       state_q, state_d;
    logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
    logic [ROM_AW-1:0] out_cnt_q, out_cnt_d;
    logic [ROM_AW-1:0] rd_idx_q, rd_idx_d;
    logic              rd_vld_q, rd_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [FCW-1:0]    fifo_cnt;
    logic [DW-1:0]     push_data, head_data;
    logic [OW-1:0]     credit_occ;
    logic              pop, issue;

    assign pop = m_axis_tvalid & m_axis_tready;

    // Occupancy after this cycle counts the read still in flight, so the FIFO can never be overrun.
    assign credit_occ = OW'(fifo_cnt) + OW'(rd_vld_q) - OW'(pop);
    assign issue      = (state_q == ST_RUN) && (issue_cnt_q != NUM_VEC_C) && (credit_occ < OW'(2));

    assign push_data = {rom_b_dout, rom_a_dout, rd_idx_q, rd_idx_q == LAST_IDX};

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        rd_idx_d    = rd_idx_q;
        rd_vld_d    = issue;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (issue) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            rd_idx_d    = issue_cnt_q[ROM_AW-1:0];
        end
        if (pop) out_cnt_d = out_cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                    busy_d      = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue_cnt_q == NUM_VEC_C) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && (out_cnt_q == LAST_IDX)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every flop updates with <= so all of them see the same pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            rd_idx_q    <= '0;
            rd_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            rd_idx_q    <= rd_idx_d;
            rd_vld_q    <= rd_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    floating_point_stim_skid #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_vld_q),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_cnt)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign rom_rd_addr   = issue_cnt_q[ROM_AW-1:0];
    assign m_axis_tvalid = (fifo_cnt != '0);
    assign m_axis_tdata  = head_data[DW-1:ROM_AW+1];
    assign m_axis_tuser  = head_data[ROM_AW:1];
    assign m_axis_tlast  = head_data[0];

endmodule

// File: tb/tb_floating_point_stim_gen.sv
// Scoreboard bench for floating_point_stim_gen: single-precision run of 10 vectors plus a double-precision single-vector instance.
module tb_floating_point_stim_gen;

    localparam int NV = 10;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  user;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_d;
    logic        busy, done, busy_d, done_d;
    logic [3:0]  rom_rd_addr, rom_rd_addr_d;
    logic [31:0] rom_a, rom_b;
    logic [63:0] rom_a_d, rom_b_d;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic [3:0]  m_axis_tuser;
    logic        tvalid_d, tready_d, tlast_d;
    logic [127:0] tdata_d;
    logic [3:0]  tuser_d;

    int    n_vec  = 0;
    int    n_miss = 0;
    beat_t exp_q[$];
    logic  model_running = 1'b0;
    logic  done_due      = 1'b0;
    logic  hold_valid    = 1'b0;
    logic [63:0] hold_data;
    logic [3:0]  hold_user;

    always #5 clk = ~clk;

    floating_point_stim_gen #(.EXP_WIDTH(8), .MAN_WIDTH(23), .NUM_VEC(NV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rom_rd_addr(rom_rd_addr), .rom_a_dout(rom_a), .rom_b_dout(rom_b),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
    );

    floating_point_stim_gen #(.EXP_WIDTH(11), .MAN_WIDTH(52), .NUM_VEC(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy_d), .done(done_d),
        .rom_rd_addr(rom_rd_addr_d), .rom_a_dout(rom_a_d), .rom_b_dout(rom_b_d),
        .m_axis_tvalid(tvalid_d), .m_axis_tready(tready_d),
        .m_axis_tdata(tdata_d), .m_axis_tlast(tlast_d), .m_axis_tuser(tuser_d)
    );

    function automatic logic [31:0] rom_b32(input logic [3:0] addr);
        case (addr)
            4'd0: return 32'h00f3_e301;
            4'd1: return 32'h3f80_0000;
            4'd2: return 32'h4049_0fdb;
            4'd3: return 32'hc000_0000;
            4'd4: return 32'h0000_0001;
            4'd5: return 32'h8000_0000;
            4'd6: return 32'h7f7f_ffff;
            4'd7: return 32'h7fc0_0000;
            4'd8: return 32'hff80_0000;
            4'd9: return 32'h7f80_0000;
            default: return 32'h3e00_0000 | 32'(addr);
        endcase
    endfunction

    function automatic logic [63:0] rom_b64(input logic [3:0] addr);
        return (addr == 4'd0) ? 64'h3b23_f176_00f3_e301 : {32'h4000_0000, 28'h0, addr};
    endfunction

    always @(posedge clk) begin
        rom_a   <= 32'hA000_0000 + 32'(rom_rd_addr);
        rom_b   <= rom_b32(rom_rd_addr);
        rom_a_d <= 64'hA000_0000 + 64'(rom_rd_addr_d);
        rom_b_d <= rom_b64(rom_rd_addr_d);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A run is accepted only when the model says the sequencer is idle; its beats follow directly from the ROM contents.
    task automatic do_start();
        start = 1'b1;
        if (!model_running) begin
            model_running = 1'b1;
            for (int i = 0; i < NV; i++) begin
                beat_t b;
                b.data = {rom_b32(4'(i)), 32'hA000_0000 + 32'(i)};
                b.user = 4'(i);
                b.last = (i == NV - 1);
                exp_q.push_back(b);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((model_running || exp_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 128'(n >= 400), 128'(1'b0));
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done_due) begin
                check("done_pulse", 128'(done), 128'(1'b1));
                check("busy_fall", 128'(busy), 128'(1'b0));
                done_due = 1'b0;
            end else if (done) begin
                check("spurious_done", 128'(done), 128'(1'b0));
            end
            if (dut.fifo_cnt > 2'd2) check("fifo_bound", 128'(dut.fifo_cnt), 128'(2));
            if (hold_valid) begin
                check("stall_tvalid", 128'(m_axis_tvalid), 128'(1'b1));
                check("stall_tdata", 128'(m_axis_tdata), 128'(hold_data));
                check("stall_tuser", 128'(m_axis_tuser), 128'(hold_user));
                hold_valid = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_beat: got tuser %0d, expected no beat", m_axis_tuser);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_tdata", 128'(m_axis_tdata), 128'(b.data));
                    check("beat_tuser", 128'(m_axis_tuser), 128'(b.user));
                    check("beat_tlast", 128'(m_axis_tlast), 128'(b.last));
                    check("beat_busy", 128'(busy), 128'(1'b1));
                    if (b.last) begin
                        done_due      = 1'b1;
                        model_running = 1'b0;
                    end
                end
            end else if (m_axis_tvalid) begin
                hold_valid = 1'b1;
                hold_data  = m_axis_tdata;
                hold_user  = m_axis_tuser;
            end
        end
    end

    initial begin
        int n;
        logic found;
        rst_n = 1'b0; start = 1'b0; start_d = 1'b0; m_axis_tready = 1'b0; tready_d = 1'b0;
        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("rst_tlast", 128'(m_axis_tlast), 128'(0));
        check("rst_tdata", 128'(m_axis_tdata), 128'(0));
        check("rst_tuser", 128'(m_axis_tuser), 128'(0));
        check("rst_addr", 128'(rom_rd_addr), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // 1: full throughput, latency of two edges from start to first tvalid
        m_axis_tready = 1'b1;
        do_start();
        @(negedge clk);
        check("lat_e0_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("lat_e0_busy", 128'(busy), 128'(1));
        @(negedge clk);
        check("lat_e1_tvalid", 128'(m_axis_tvalid), 128'(0));
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check("b2b_tvalid", 128'(m_axis_tvalid), 128'(1));
        end
        tick();
        wait_idle("t1");

        // 2: random backpressure
        do_start();
        n = 0;
        while ((model_running || exp_q.size() != 0) && n < 500) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_axis_tready = 1'b1;
        wait_idle("t2");

        // 3: long stall buffers exactly two vectors, then a back-to-back release
        m_axis_tready = 1'b0;
        do_start();
        repeat (20) tick();
        check("stall_addr", 128'(rom_rd_addr), 128'(2));
        check("stall_fifo_cnt", 128'(dut.fifo_cnt), 128'(2));
        check("stall_head_tuser", 128'(m_axis_tuser), 128'(0));
        m_axis_tready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check("release_tvalid", 128'(m_axis_tvalid), 128'(1));
        end
        tick();
        wait_idle("t3");

        // 4: start while busy ignored; start in the done cycle begins a new run
        do_start();
        repeat (3) tick();
        do_start();
        n = 0;
        while (model_running && n < 200) begin
            tick();
            n++;
        end
        check("t4_timeout", 128'(n >= 200), 128'(0));
        check("t4_done_cycle", 128'(done), 128'(1));
        do_start();
        wait_idle("t4");

        // 5: asynchronous reset mid-run under backpressure
        do_start();
        n = 0;
        while (exp_q.size() > NV - 4 && n < 200) begin
            tick();
            n++;
        end
        m_axis_tready = 1'b0;
        repeat (3) tick();
        check("t5_head_tuser", 128'(m_axis_tuser), 128'(4));
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        check("arst_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("arst_tdata", 128'(m_axis_tdata), 128'(0));
        check("arst_tuser", 128'(m_axis_tuser), 128'(0));
        check("arst_tlast", 128'(m_axis_tlast), 128'(0));
        check("arst_addr", 128'(rom_rd_addr), 128'(0));
        exp_q.delete();
        model_running = 1'b0;
        done_due      = 1'b0;
        hold_valid    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (4) tick();
        check("post_rst_done", 128'(done), 128'(0));
        check("post_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        do_start();
        wait_idle("t5");

        // 6: double precision, single vector
        tready_d = 1'b1;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = tvalid_d;
        end
        check("dbl_tvalid", 128'(found), 128'(1));
        check("dbl_tdata", tdata_d, {64'h3b23_f176_00f3_e301, 64'h0000_0000_A000_0000});
        check("dbl_tuser", 128'(tuser_d), 128'(0));
        check("dbl_tlast", 128'(tlast_d), 128'(1));
        @(negedge clk);
        check("dbl_done", 128'(done_d), 128'(1));
        check("dbl_single_beat", 128'(tvalid_d), 128'(0));
        tick();

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
